pll_phase_sched: RTL
====================

// Module: pll_phase_sched
// PURPOSE
//  Fast-clock scheduler driven by the phase count of the PLL slow/fast sync counter.
//  Checks that the phase sequence is consistent and declares lock after a set number of clean wraps.
//  Once locked, it emits one capture strobe per slow period at a fixed safe phase.
//  It latches the slow-domain word into a valid/ready output register feeding the fast-domain datapath.
// PARAMETERS
//  RATIO       8   slow/fast clock period ratio; phase counts 0..RATIO-1; RATIO>=2
//  DATA_WIDTH  14  width of slw_data / out_data
//  CAP_PHASE   4   phase at which slw_data is sampled; 0<=CAP_PHASE<RATIO
//  LOCK_WRAPS  4   consecutive clean wraps needed for lock; >=1
//  ERR_WIDTH   8   width of err_cnt (PLL_SCHED_STATS_EN only)
// PORTS
//  clk       in   1               fast clock; all logic on posedge
//  rst       in   1               synchronous, active-high reset
//  en        in   1               scheduler enable; 0 forces IDLE
//  phase     in   $clog2(RATIO)   phase count from the sync counter
//  slw_data  in   DATA_WIDTH      slow-domain word; stable around CAP_PHASE
//  out_data  out  DATA_WIDTH      captured word
//  out_valid out  1               out_data valid
//  out_ready in   1               downstream accept
//  cap_stb   out  1               one-cycle capture pulse
//  locked    out  1               phase sequence locked
//  ovf       out  1               sticky: capture dropped because output still pending
//  ovf_clr   in   1               clears ovf
// BEHAVIOUR
//  - Reset: state=IDLE; out_data, out_valid, cap_stb, locked, ovf, wrap count and err_cnt all 0. Previous-phase register = RATIO-1.
//  - Every cycle:
//    - prev_phase <= phase.
//    - exp = (prev_phase==RATIO-1) ? 0 : prev_phase+1.
//    - mis = (phase!=exp) && state!=IDLE.
//    - prev_phase is not checked in IDLE.
//  - FSM:
//    - IDLE: locked=0. en=1 -> ACQ with wrap count=0.
//    - ACQ: mis -> wrap count=0. Else, if phase==0, count+1. Count reaching LOCK_WRAPS -> LOCKED.
//    - LOCKED: mis -> ACQ with count=0.
//    - en=0 in any state -> IDLE next cycle. en has priority over mis.
//  - locked is registered. It is 1 the cycle after the LOCKED transition and 0 the cycle after leaving LOCKED.
//  - Capture condition C = (state==LOCKED) && !mis && phase==CAP_PHASE && en.
//    - Cycle after C: cap_stb=1 for exactly one cycle.
//    - slw_data sampled on the C cycle; latency 1.
//  - Output handshake: transfer when out_valid && out_ready. out_data holds while out_valid && !out_ready.
//    - C, output empty or transferring this cycle -> out_data<=slw_data, out_valid=1.
//    - C, out_valid=1 and !out_ready -> new word dropped, old kept, ovf<=1.
//    - Transfer without C -> out_valid<=0.
//  - ovf: sticky until ovf_clr or rst. ovf_clr with a same-cycle set -> ovf=1 (set wins).
//  - Leaving LOCKED via mis: pending out_valid retained until accepted. No further captures until relocked.
//  - en=0: out_valid cleared next cycle; pending word discarded; ovf unchanged.
//  - A single mismatched phase value causes two mis cycles (entering and leaving). The second only resets the count again.
// CONFIGURATION
//  - PLL_SCHED_STATS_EN defined:
//    - adds output err_cnt [ERR_WIDTH-1:0], counting mis cycles that occur while in LOCKED;
//    - err_cnt saturates at all-ones and clears on rst only.
//  - PLL_SCHED_STATS_EN undefined: port err_cnt and its logic absent; all other behaviour identical.
// TESTING
//  - T1 lock: RATIO=8, en=1, clean phase 0..7 repeating -> locked=1 one cycle after the 4th phase==0, no cap_stb earlier.
//  - T2 capture: locked, out_ready=1, slw_data=0x1A5 at phase 4 -> cap_stb=1 and out_data=0x1A5, out_valid=1 next cycle. Exactly one cap_stb per 8 cycles.
//  - T3 backpressure: out_ready=0 across two capture phases -> first word held, ovf=1 after second C. ovf_clr -> ovf=0.
//  - T4 simultaneous: out_valid=1 and out_ready=1 on the C cycle -> old word accepted, new word loaded, out_valid stays 1, ovf=0.
//  - T5 glitch: in LOCKED, phase jumps 3->6 -> locked=0 next cycle, no cap_stb until 4 clean wraps, pending word still handshakes.
//  - T6 en/rst mid-operation:
//    - en=0 while out_valid=1 -> out_valid=0, locked=0, state IDLE next cycle.
//    - rst -> all outputs 0.
//    - With PLL_SCHED_STATS_EN: T5 glitch gives err_cnt=1 (one mis cycle while LOCKED).

Source files
------------

// File: rtl/pll_phase_sched.sv
// pll_phase_sched
//   Fast-clock scheduler driven by the phase count of the PLL slow/fast sync
//   counter. It checks that the phase sequence advances cleanly and declares
//   lock after LOCK_WRAPS consecutive clean wraps. Once locked, it samples
//   slw_data once per slow period at CAP_PHASE into a valid/ready output
//   register.
//
//   Optional feature macro: PLL_SCHED_STATS_EN adds err_cnt, a saturating
//   count of phase mismatches seen while locked.
//
// Ports
//   clk       in   fast clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   en        in   scheduler enable; 0 returns to IDLE
//   phase     in   phase count 0..RATIO-1
//   slw_data  in   slow-domain word, stable around CAP_PHASE
//   out_data  out  captured word
//   out_valid out  out_data valid
//   out_ready in   downstream accept
//   cap_stb   out  one-cycle capture pulse
//   locked    out  phase sequence locked
//   ovf       out  sticky: capture dropped while output still pending
//   ovf_clr   in   clears ovf
//   err_cnt   out  (PLL_SCHED_STATS_EN only) mismatches while locked
module pll_phase_sched #(
  parameter int unsigned RATIO      = 8,
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned CAP_PHASE  = 4,
  parameter int unsigned LOCK_WRAPS = 4,
  parameter int unsigned ERR_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [$clog2(RATIO)-1:0] phase,
  input  logic [DATA_WIDTH-1:0]    slw_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     cap_stb,
  output logic                     locked,
  output logic                     ovf,
`ifdef PLL_SCHED_STATS_EN
  output logic [ERR_WIDTH-1:0]     err_cnt,
`endif
  input  logic                     ovf_clr
);

  localparam int unsigned PW = $clog2(RATIO);
  localparam int unsigned CW = $clog2(LOCK_WRAPS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] prev_phase;
  logic [PW-1:0] exp_phase;
  logic [CW-1:0] wrap_cnt, wrap_cnt_nxt, wrap_cnt_inc;
  logic          mis;
  logic          cap;
  logic          xfer;

  always_comb begin
    exp_phase = (prev_phase == PW'(RATIO - 1)) ? '0 : prev_phase + 1'b1;
    mis       = (phase != exp_phase) && (state != S_IDLE);
    cap       = (state == S_LOCKED) && !mis && (phase == PW'(CAP_PHASE)) && en;
    xfer      = out_valid && out_ready;
  end

  // en outranks mis in every state.
  always_comb begin
    state_nxt    = state;
    wrap_cnt_nxt = wrap_cnt;
    wrap_cnt_inc = wrap_cnt + 1'b1;
    if (!en) begin
      state_nxt    = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt    = S_ACQ;
          wrap_cnt_nxt = '0;
        end
        S_ACQ: begin
          if (mis) begin
            wrap_cnt_nxt = '0;
          end else if (phase == '0) begin
            wrap_cnt_nxt = wrap_cnt_inc;
            if (wrap_cnt_inc == CW'(LOCK_WRAPS)) state_nxt = S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (mis) begin
            state_nxt    = S_ACQ;
            wrap_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = S_IDLE;
          wrap_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wrap_cnt   <= '0;
      prev_phase <= PW'(RATIO - 1);
      locked     <= 1'b0;
      cap_stb    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wrap_cnt   <= wrap_cnt_nxt;
      prev_phase <= phase;
      locked     <= (state_nxt == S_LOCKED);
      cap_stb    <= cap;
    end
  end

  // A capture into a full, non-draining register is dropped and flagged;
  // the set of ovf wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (!en) begin
        out_valid <= 1'b0;
      end else if (cap && (!out_valid || out_ready)) begin
        out_data  <= slw_data;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end

      if (cap && out_valid && !out_ready) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef PLL_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((state == S_LOCKED) && mis && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
